sm83_regfile_gen: RTL

Parametrised register-pair file with an integrated address latch/incrementer unit (AU). It supersedes the fixed BC/DE/HL/AF/SP/WZ/PC storage and the separate address-latch path in the sm83 core. It generalises word size and pair count, and adds a pipelined, back-to-back-capable inc/dec/writeback sequencer with write forwarding. It sits between the control unit, the data-bus matrices and the external address pins.

---
 rtl/sm83_regfile_gen_if.sv | 39 +++
 rtl/sm83_regfile_gen.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/sm83_regfile_gen_if.sv
// Bus between the control unit and the register-pair file: byte read/write
// ports plus the address-unit request/status/address signals.
interface sm83_regfile_gen_if #(
    parameter int WORD_SIZE = 8,
    parameter int NUM_PAIRS = 8
);
    localparam int PSEL_W    = $clog2(NUM_PAIRS);
    localparam int ADR_WIDTH = 2 * WORD_SIZE;

    logic [PSEL_W-1:0]    rd_pair;
    logic                 rd_hi;
    logic [WORD_SIZE-1:0] rd_data;

    logic                 wr_en;
    logic [PSEL_W-1:0]    wr_pair;
    logic                 wr_hi;
    logic [WORD_SIZE-1:0] wr_data;

    logic                 au_start;
    logic [PSEL_W-1:0]    au_pair;
    logic [1:0]           au_mode;
    logic                 au_ff;
    logic                 au_busy;
    logic                 au_done;
    logic                 au_wrap;
    logic [ADR_WIDTH-1:0] adr;

    modport master (
        output rd_pair, rd_hi, wr_en, wr_pair, wr_hi, wr_data,
               au_start, au_pair, au_mode, au_ff,
        input  rd_data, au_busy, au_done, au_wrap, adr
    );

    modport slave (
        input  rd_pair, rd_hi, wr_en, wr_pair, wr_hi, wr_data,
               au_start, au_pair, au_mode, au_ff,
        output rd_data, au_busy, au_done, au_wrap, adr
    );
endinterface

// File: rtl/sm83_regfile_gen.sv
// Register-pair file with an address latch/incrementer unit: latch a pair onto adr,
// then inc/dec/pass it back into the pair two cycles later; back-to-back issue in WB.
module sm83_regfile_gen #(
    parameter int                       WORD_SIZE = 8,
    parameter int                       NUM_PAIRS = 8,
    parameter int                       AF_INDEX  = 3,
    parameter logic [WORD_SIZE-1:0]     FLAG_MASK = 'hF0,
    parameter int                       PC_INDEX  = 5,
    parameter logic [2*WORD_SIZE-1:0]   PC_RESET  = '0
) (
    input  logic              clk,
    input  logic              reset,
    sm83_regfile_gen_if.slave bus
);
    localparam int ADR_WIDTH = 2 * WORD_SIZE;
    localparam int PSEL_W    = $clog2(NUM_PAIRS);

    localparam logic [PSEL_W-1:0] AF_SEL = PSEL_W'(AF_INDEX);

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_INC  = 2'b01;
    localparam logic [1:0] MODE_DEC  = 2'b10;
    localparam logic [1:0] MODE_NOWB = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LATCH = 2'd1,
        S_WB    = 2'd2
    } au_state_t;

    au_state_t             state_q, state_d;
    logic [ADR_WIDTH-1:0]  adr_q, adr_d;
    logic [PSEL_W-1:0]     pair_q, pair_d;
    logic [1:0]            mode_q, mode_d;

    logic [WORD_SIZE-1:0]  hi_q [NUM_PAIRS];
    logic [WORD_SIZE-1:0]  lo_q [NUM_PAIRS];
    logic [WORD_SIZE-1:0]  hi_d [NUM_PAIRS];
    logic [WORD_SIZE-1:0]  lo_d [NUM_PAIRS];

    logic [ADR_WIDTH-1:0]  result;
    logic [ADR_WIDTH-1:0]  src_val;
    logic [ADR_WIDTH-1:0]  latch_val;
    logic                  wb_en;
    logic                  accept;
    logic [WORD_SIZE-1:0]  rd_byte;

    // Pair counts that are not a power of two leave unused select codes.
    function automatic logic in_range(input logic [PSEL_W-1:0] p);
        return ({1'b0, p} < (PSEL_W+1)'(NUM_PAIRS));
    endfunction

    always_comb begin
        result = adr_q;
        case (mode_q)
            MODE_INC: result = adr_q + ADR_WIDTH'(1);
            MODE_DEC: result = adr_q - ADR_WIDTH'(1);
            default:  result = adr_q;
        endcase
    end

    assign wb_en  = (state_q == S_WB) && (mode_q != MODE_NOWB) && in_range(pair_q);
    assign accept = bus.au_start && (state_q != S_LATCH);

    // A start issued in WB on the pair being written back must see R, not storage.
    always_comb begin
        src_val = '0;
        if (wb_en && (bus.au_pair == pair_q)) begin
            src_val = result;
        end else if (in_range(bus.au_pair)) begin
            src_val = {hi_q[bus.au_pair], lo_q[bus.au_pair]};
        end
        latch_val = src_val;
        if (bus.au_ff) begin
            latch_val[ADR_WIDTH-1:WORD_SIZE] = '1;
        end
    end

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        pair_d  = pair_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE:  if (bus.au_start) state_d = S_LATCH;
            S_LATCH: state_d = S_WB;
            S_WB:    state_d = bus.au_start ? S_LATCH : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            adr_d  = latch_val;
            pair_d = bus.au_pair;
            mode_d = bus.au_mode;
        end
    end

    // Byte write is applied after writeback so it wins its half on a collision.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (wb_en) begin
            hi_d[pair_q] = result[ADR_WIDTH-1:WORD_SIZE];
            lo_d[pair_q] = result[WORD_SIZE-1:0];
        end
        if (bus.wr_en && in_range(bus.wr_pair)) begin
            if (bus.wr_hi) begin
                hi_d[bus.wr_pair] = bus.wr_data;
            end else begin
                lo_d[bus.wr_pair] = bus.wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            adr_q   <= '0;
            pair_q  <= '0;
            mode_q  <= MODE_PASS;
            for (int i = 0; i < NUM_PAIRS; i++) begin
                if (i == PC_INDEX) begin
                    hi_q[i] <= PC_RESET[ADR_WIDTH-1:WORD_SIZE];
                    lo_q[i] <= PC_RESET[WORD_SIZE-1:0];
                end else begin
                    hi_q[i] <= '0;
                    lo_q[i] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            pair_q  <= pair_d;
            mode_q  <= mode_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        rd_byte = '0;
        if (in_range(bus.rd_pair)) begin
            rd_byte = bus.rd_hi ? hi_q[bus.rd_pair] : lo_q[bus.rd_pair];
        end
        if ((bus.rd_pair == AF_SEL) && !bus.rd_hi) begin
            rd_byte = rd_byte & FLAG_MASK;
        end
    end

    assign bus.rd_data = rd_byte;
    assign bus.adr     = adr_q;
    assign bus.au_busy = (state_q == S_LATCH);
    assign bus.au_done = (state_q == S_WB);
    assign bus.au_wrap = (state_q == S_WB) &&
                         (((mode_q == MODE_INC) && (adr_q == '1)) ||
                          ((mode_q == MODE_DEC) && (adr_q == '0)));
endmodule
